// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
//   Read-side drain stage sitting directly behind a FIFO. It requests words
//   from the FIFO, absorbs the FIFO's one-cycle read latency in a 2-entry
//   skid buffer, and presents the words as a valid/ready stream. Words are
//   never lost or reordered, and the stage sustains one word per cycle.
//
// Parameters
//   FIFO_WIDTH  data word width (must match the FIFO instance)
//   CNT_WIDTH   width of the delivered-word counter
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst_n           asynchronous active-low reset
//   fifo_rd_en      read request to the FIFO (combinational)
//   fifo_data_out   FIFO read data, valid the cycle after an accepted read
//   fifo_empty      FIFO empty flag
//   fifo_underflow  FIFO underflow flag
//   m_data          stream data (registered, head of skid buffer)
//   m_valid         stream valid (registered)
//   m_ready         consumer ready
//   err_underflow   sticky underflow error, cleared only by reset
//   rd_count        words delivered since reset (wraps)
//
// Build option
//   FIFO_RD_CNT_EN  when defined, rd_count is a live counter; otherwise it
//                   is tied to zero and the counter logic is not built.
module fifo_rd_stream #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  err_underflow,
  output logic [CNT_WIDTH-1:0]  rd_count
);

  logic [1:0]            occ_reg, occ_next;
  logic                  in_flight_reg;
  logic [FIFO_WIDTH-1:0] head_reg, head_next;
  logic [FIFO_WIDTH-1:0] tail_reg, tail_next;
  logic                  err_reg;
  logic                  pop;
  logic [1:0]            occ_after_pop;
  logic [2:0]            pending;

  assign m_valid       = (occ_reg != 2'd0);
  assign m_data        = head_reg;
  assign err_underflow = err_reg;
  assign pop           = m_valid & m_ready;

  always_comb begin
    occ_after_pop = occ_reg - {1'b0, pop};
    // Words that will occupy the buffer once the in-flight read lands;
    // only issue another read if a slot is still free for it.
    pending       = {1'b0, occ_after_pop} + {2'b00, in_flight_reg};
    fifo_rd_en    = rst_n & ~fifo_empty & (pending < 3'd2);
    occ_next      = pending[1:0];

    head_next = head_reg;
    tail_next = tail_reg;
    // Shift tail into head only when a real second entry exists, so that
    // m_data keeps its last value when the buffer runs dry.
    if (pop && occ_reg == 2'd2) begin
      head_next = tail_reg;
    end
    // The arriving word goes into the first free slot after the pop.
    if (in_flight_reg) begin
      if (occ_after_pop == 2'd0) begin
        head_next = fifo_data_out;
      end else begin
        tail_next = fifo_data_out;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_reg       <= 2'd0;
      in_flight_reg <= 1'b0;
      head_reg      <= '0;
      tail_reg      <= '0;
      err_reg       <= 1'b0;
    end else begin
      occ_reg       <= occ_next;
      in_flight_reg <= fifo_rd_en;
      head_reg      <= head_next;
      tail_reg      <= tail_next;
      if (fifo_underflow) begin
        err_reg <= 1'b1;
      end
    end
  end

`ifdef FIFO_RD_CNT_EN
  logic [CNT_WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (pop) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign rd_count = count_reg;
`else
  assign rd_count = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream
//   Directed bench for fifo_rd_stream. A queue-based FIFO drives the DUT's
//   read port; a queue-based model of the drain stage predicts the stream
//   outputs each cycle. Inputs change on the falling edge, outputs are
//   compared 1ns later, model/FIFO state advances 1ns after the rising edge.
module tb_fifo_rd_stream;

  localparam int W  = 16;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifo_rd_en;
  logic [W-1:0]  fifo_data_out;
  logic          fifo_empty;
  logic          fifo_underflow;
  logic [W-1:0]  m_data;
  logic          m_valid;
  logic          m_ready;
  logic          err_underflow;
  logic [CW-1:0] rd_count;

  fifo_rd_stream #(.FIFO_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_data_out (fifo_data_out),
    .fifo_empty    (fifo_empty),
    .fifo_underflow(fifo_underflow),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .err_underflow (err_underflow),
    .rd_count      (rd_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Environment FIFO
  logic [W-1:0] fq[$];
  // Drain-stage model: words held for the consumer, read in flight, etc.
  logic [W-1:0] mb[$];
  logic [W-1:0] out_q[$];
  logic [W-1:0] src_q[$];
  bit           inflight_m;
  bit           err_m;
  int unsigned  cnt_m;
  int           rd_issued;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_count(input int unsigned c);
`ifdef FIFO_RD_CNT_EN
    return c;
`else
    return (c == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic clear_model();
    mb.delete();
    fq.delete();
    inflight_m = 0;
    err_m      = 0;
    cnt_m      = 0;
  endtask

  task automatic push_word(input logic [W-1:0] w);
    fq.push_back(w);
    src_q.push_back(w);
  endtask

  // One clock cycle: compare, cross the rising edge, advance models.
  task automatic tick();
    bit exp_pop, exp_rd, acc, pop_m, uf;
    int sum;
    if (!rst_n) clear_model();
    fifo_empty = (fq.size() == 0);
    #1;
    exp_pop = rst_n && (mb.size() > 0) && m_ready;
    sum     = mb.size() + int'(inflight_m) - int'(exp_pop);
    exp_rd  = rst_n && !fifo_empty && (sum < 2);
    chk("fifo_rd_en", fifo_rd_en, exp_rd);
    chk("rd_while_empty", fifo_rd_en & fifo_empty, 0);
    chk("m_valid", m_valid, mb.size() > 0);
    if (mb.size() > 0) chk("m_data", m_data, mb[0]);
    chk("err_underflow", err_underflow, err_m);
    chk("rd_count", rd_count, exp_count(cnt_m));
    acc   = fifo_rd_en && !fifo_empty;
    pop_m = exp_pop;
    uf    = fifo_underflow;
    if (acc) rd_issued++;
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (pop_m) begin
        out_q.push_back(mb.pop_front());
        cnt_m++;
      end
      if (inflight_m) mb.push_back(fifo_data_out);
      inflight_m = exp_rd;
      if (uf) err_m = 1;
      if (acc) fifo_data_out = fq.pop_front();
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n          = 1'b0;
    m_ready        = 1'b0;
    fifo_empty     = 1'b1;
    fifo_underflow = 1'b0;
    fifo_data_out  = '0;
    clear_model();
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;

    // Idle with an empty FIFO.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_m_data", m_data, 0);
      chk("idle_m_valid", m_valid, 0);
    end

    // Streaming at full rate: 8 words, pops on edges 3..10.
    m_ready = 1'b1;
    out_q.delete();
    for (int i = 1; i <= 8; i++) push_word(W'(i));
    for (int i = 0; i < 10; i++) tick();
    chk("stream_len", out_q.size(), 8);
    for (int i = 0; i < out_q.size(); i++) chk("stream_word", out_q[i], i + 1);
    chk("stream_count", rd_count, exp_count(8));

    // Back-pressure: only two reads during the 5-cycle stall.
    m_ready = 1'b0;
    out_q.delete();
    rd_issued = 0;
    for (int i = 1; i <= 8; i++) push_word(W'(i));
    for (int i = 0; i < 5; i++) tick();
    chk("stall_reads", rd_issued, 2);
    chk("stall_m_data", m_data, 16'h0001);
    chk("stall_m_valid", m_valid, 1);
    m_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("stall_len", out_q.size(), 8);
    for (int i = 0; i < out_q.size(); i++) chk("stall_word", out_q[i], i + 1);

    // Random stream with m_ready toggling every cycle.
    out_q.delete();
    src_q.delete();
    for (int i = 0; i < 100; i++) push_word(W'($urandom));
    for (int i = 0; i < 400 && out_q.size() < 100; i++) begin
      m_ready = ~m_ready;
      tick();
    end
    chk("rand_len", out_q.size(), 100);
    for (int i = 0; i < out_q.size() && i < src_q.size(); i++)
      chk("rand_word", out_q[i], src_q[i]);
    m_ready = 1'b1;

    // Underflow pulse is sticky.
    fifo_underflow = 1'b1;
    tick();
    fifo_underflow = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("err_sticky", err_underflow, 1);

    // Asynchronous reset with a full buffer.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(W'(16'hA0 + i));
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_valid", m_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_count", rd_count, 0);
    chk("rst_err", err_underflow, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    @(negedge clk);
    tick();
    rst_n   = 1'b1;
    m_ready = 1'b1;
    out_q.delete();
    for (int i = 1; i <= 3; i++) push_word(W'(16'h50 + i));
    for (int i = 0; i < 6; i++) tick();
    chk("resume_len", out_q.size(), 3);
    for (int i = 0; i < out_q.size(); i++) chk("resume_word", out_q[i], 16'h50 + i + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
